// File: rtl/ppi_bus_sequencer.sv
// Bus master for an 8255-style PPI: round-robin arbitration between two requesters,
// timed setup/strobe/hold cycles, and a control-word write after every reset.
module ppi_bus_sequencer #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1,
  parameter logic [7:0]  INIT_CTRL  = 8'h80
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic [1:0] we,
  input  logic [1:0] addr0,
  input  logic [1:0] addr1,
  input  logic [7:0] wdata0,
  input  logic [7:0] wdata1,
  output logic [1:0] done,
  output logic [7:0] rdata,
  output logic       busy,
  output logic       cs,
  output logic       read,
  output logic       write,
  output logic [1:0] A,
  output logic [7:0] d_out,
  output logic       d_oe,
  input  logic [7:0] d_in
);

  localparam int unsigned MAX_SS  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_CYC = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {S_INIT, S_IDLE, S_SETUP, S_STROBE, S_HOLD} state_t;

  state_t        state, next_state;
  logic [CW-1:0] cnt;
  logic          cnt_zero;
  logic          cyc_we, cyc_id, cyc_init, ptr;
  logic [1:0]    eff_req;
  logic          grant, gnt_id;
  logic          active;

  function automatic logic [CW-1:0] reload(input state_t s);
    case (s)
      S_SETUP:  reload = CW'(SETUP_CYC - 1);
      S_STROBE: reload = CW'(STROBE_CYC - 1);
      S_HOLD:   reload = CW'(HOLD_CYC - 1);
      default:  reload = '0;
    endcase
  endfunction

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_INIT;
      cnt   <= '0;
    end else begin
      state <= next_state;
      if (next_state != state)
        cnt <= reload(next_state);
      else if (!cnt_zero)
        cnt <= cnt - 1'b1;
    end
  end

  // A requester still holds req during its own done pulse; mask it so it is not re-granted.
  always_comb begin
    eff_req = req & ~done;
    grant   = |eff_req;
    gnt_id  = (eff_req == 2'b11) ? ptr : eff_req[1];
  end

  always_comb begin
    next_state = state;
    case (state)
      S_INIT:   next_state = S_SETUP;
      S_IDLE:   if (grant) next_state = S_SETUP;
      S_SETUP:  if (cnt_zero) next_state = S_STROBE;
      S_STROBE: if (cnt_zero) next_state = S_HOLD;
      S_HOLD:   if (cnt_zero) next_state = S_IDLE;
      default:  next_state = S_INIT;
    endcase
  end

  always_comb begin
    active = (state == S_SETUP) || (state == S_STROBE) || (state == S_HOLD);
    cs     = ~active;
    read   = ~((state == S_STROBE) && !cyc_we);
    write  = ~((state == S_STROBE) && cyc_we);
    d_oe   = active && cyc_we;
    busy   = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A        <= '0;
      d_out    <= '0;
      cyc_we   <= 1'b0;
      cyc_id   <= 1'b0;
      cyc_init <= 1'b0;
      ptr      <= 1'b0;
      rdata    <= '0;
      done     <= '0;
    end else begin
      done <= '0;
      if (state == S_INIT) begin
        A        <= 2'b11;
        d_out    <= INIT_CTRL;
        cyc_we   <= 1'b1;
        cyc_init <= 1'b1;
      end else if (state == S_IDLE && grant) begin
        cyc_id   <= gnt_id;
        cyc_init <= 1'b0;
        ptr      <= ~gnt_id;
        cyc_we   <= we[gnt_id];
        A        <= gnt_id ? addr1 : addr0;
        if (we[gnt_id])
          d_out <= gnt_id ? wdata1 : wdata0;
      end
      if (state == S_STROBE && cnt_zero && !cyc_we)
        rdata <= d_in;
      if (state == S_HOLD && cnt_zero && !cyc_init)
        done[cyc_id] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ppi_bus_sequencer.sv
// Directed bench for ppi_bus_sequencer: table-driven single transactions plus
// init, arbitration, mid-cycle reset and non-default timing sequences.
module tb_ppi_bus_sequencer;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [1:0] req, we, addr0, addr1;
  logic [7:0] wdata0, wdata1, d_in;
  logic [1:0] done;
  logic [7:0] rdata, d_out;
  logic       busy, cs, read, write, d_oe;
  logic [1:0] A;

  logic       reset6;
  logic [1:0] req6, we6, addr6;
  logic [7:0] wdata6, d_in6;
  logic [1:0] done6;
  logic [7:0] rdata6, d_out6;
  logic       busy6, cs6, read6, write6, d_oe6;
  logic [1:0] A6;

  ppi_bus_sequencer dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1), .done(done), .rdata(rdata), .busy(busy),
    .cs(cs), .read(read), .write(write), .A(A), .d_out(d_out), .d_oe(d_oe), .d_in(d_in)
  );

  ppi_bus_sequencer #(.SETUP_CYC(3), .STROBE_CYC(1), .HOLD_CYC(2), .INIT_CTRL(8'h80)) dut6 (
    .clk(clk), .reset(reset6), .req(req6), .we(we6), .addr0(addr6), .addr1(addr6),
    .wdata0(wdata6), .wdata1(wdata6), .done(done6), .rdata(rdata6), .busy(busy6),
    .cs(cs6), .read(read6), .write(write6), .A(A6), .d_out(d_out6), .d_oe(d_oe6), .d_in(d_in6)
  );

  int checks = 0;
  int fails  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int         id;
    logic       w;
    logic [1:0] a;
    logic [7:0] wd;
    logic [7:0] din;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t tbl[4];

  // Expects reset released at #1 after an edge; observes the control-word write.
  task automatic init_check(input string tag);
    int wlow = 0, rlow = 0, cslow = 0, dn = 0;
    bit idle = 0;
    for (int c = 0; c < 20 && !idle; c++) begin
      @(posedge clk); #1;
      if (!write) begin
        wlow++;
        if (wlow == 1) begin
          check({tag, "_A"}, A, 2'b11);
          check({tag, "_dout"}, d_out, 8'h80);
          check({tag, "_doe"}, d_oe, 1'b1);
        end
      end
      if (!read) rlow++;
      if (!cs) cslow++;
      if (done != 2'b00) dn++;
      if (!busy) idle = 1;
    end
    check({tag, "_reached_idle"}, idle, 1'b1);
    check({tag, "_write_low_clks"}, wlow, 2);
    check({tag, "_read_low_clks"}, rlow, 0);
    check({tag, "_cs_low_clks"}, cslow, 4);
    check({tag, "_done_pulses"}, dn, 0);
  endtask

  task automatic txn(input int k, input vec_t v);
    int n = 0, slow = 0;
    bit got = 0;
    string tag;
    tag = $sformatf("vec%0d", k);
    if (v.id == 0) begin we[0] = v.w; addr0 = v.a; wdata0 = v.wd; end
    else begin we[1] = v.w; addr1 = v.a; wdata1 = v.wd; end
    d_in = v.din;
    req[v.id] = 1'b1;
    while (n < 20 && !got) begin
      @(posedge clk); #1;
      n++;
      if (n == 1) begin
        // scramble requester inputs after grant; latched values must be used
        if (v.id == 0) begin we[0] = ~v.w; addr0 = ~v.a; wdata0 = ~v.wd; end
        else begin we[1] = ~v.w; addr1 = ~v.a; wdata1 = ~v.wd; end
      end
      if (!read || !write) begin
        slow++;
        if (slow == 1) begin
          check({tag, "_strobe_kind"}, {read, write}, v.w ? 2'b10 : 2'b01);
          check({tag, "_A"}, A, v.a);
          check({tag, "_doe"}, d_oe, v.w);
          if (v.w) check({tag, "_dout"}, d_out, v.wd);
        end
      end
      if (done != 2'b00) got = 1;
    end
    check({tag, "_latency"}, n, 5);
    check({tag, "_strobe_clks"}, slow, 2);
    check({tag, "_done_vec"}, done, (v.id == 0) ? 2'b01 : 2'b10);
    check({tag, "_rdata"}, rdata, v.exp_rd);
    check({tag, "_cs_at_done"}, cs, 1'b1);
    req[v.id] = 1'b0;
    @(posedge clk); #1;
    check({tag, "_done_one_clk"}, done, 2'b00);
  endtask

  initial begin
    int ng, wl, rl, cl, n;
    bit prev_cs, prev_busy, idle, got;
    logic order[4];

    tbl[0] = '{id: 0, w: 1'b1, a: 2'd0, wd: 8'h5A, din: 8'h00, exp_rd: 8'h00};
    tbl[1] = '{id: 1, w: 1'b0, a: 2'd1, wd: 8'h00, din: 8'hC3, exp_rd: 8'hC3};
    tbl[2] = '{id: 0, w: 1'b0, a: 2'd3, wd: 8'h00, din: 8'h7E, exp_rd: 8'h7E};
    tbl[3] = '{id: 1, w: 1'b1, a: 2'd2, wd: 8'hA5, din: 8'h3C, exp_rd: 8'h7E};

    reset = 1'b1; req = '0; we = '0; addr0 = '0; addr1 = '0;
    wdata0 = '0; wdata1 = '0; d_in = '0;
    reset6 = 1'b1; req6 = '0; we6 = '0; addr6 = '0; wdata6 = '0; d_in6 = 8'h99;

    // reset values and the initial control-word write
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs, 1'b1);
    check("rst_read", read, 1'b1);
    check("rst_write", write, 1'b1);
    check("rst_doe", d_oe, 1'b0);
    check("rst_A", A, 2'b00);
    check("rst_dout", d_out, 8'h00);
    check("rst_rdata", rdata, 8'h00);
    check("rst_done", done, 2'b00);
    check("rst_busy", busy, 1'b1);
    reset = 1'b0;
    init_check("init");

    for (int k = 0; k < 4; k++) txn(k, tbl[k]);

    // both requesting continuously: grants alternate starting with 0
    we = 2'b11; addr0 = 2'd0; addr1 = 2'd1; wdata0 = 8'h11; wdata1 = 8'h22;
    req = 2'b11;
    ng = 0; prev_cs = cs; prev_busy = busy;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      @(posedge clk); #1;
      if (!cs && prev_cs) check($sformatf("rr_idle_gap%0d", ng), prev_busy, 1'b0);
      if (!read && !write) check("rr_strobe_overlap", {read, write}, 2'b11);
      if (done != 2'b00) begin
        order[ng] = done[1];
        ng++;
      end
      prev_cs = cs; prev_busy = busy;
    end
    req = 2'b00;
    check("rr_grants", ng, 4);
    for (int i = 0; i < 4; i++) check($sformatf("rr_order%0d", i), order[i], i[0]);
    @(posedge clk); #1;

    // reset in the second strobe clock aborts the cycle
    we[0] = 1'b1; addr0 = 2'd2; wdata0 = 8'h33; req[0] = 1'b1;
    got = 0;
    for (int c = 0; c < 10 && !got; c++) begin
      @(posedge clk); #1;
      if (!write) got = 1;
    end
    check("abort_first_strobe", got, 1'b1);
    @(posedge clk); #1;
    check("abort_second_strobe", write, 1'b0);
    reset = 1'b1; req = 2'b00;
    @(posedge clk); #1;
    check("abort_cs", cs, 1'b1);
    check("abort_strobes", {read, write}, 2'b11);
    check("abort_doe", d_oe, 1'b0);
    check("abort_done", done, 2'b00);
    check("abort_busy", busy, 1'b1);
    reset = 1'b0;
    init_check("reinit");

    // non-default timing 3/1/2
    reset6 = 1'b0;
    wl = 0; cl = 0; idle = 0;
    for (int c = 0; c < 30 && !idle; c++) begin
      @(posedge clk); #1;
      if (!cs6) cl++;
      if (!write6) begin
        wl++;
        check("p6_init_A", A6, 2'b11);
      end
      if (!busy6) idle = 1;
    end
    check("p6_init_idle", idle, 1'b1);
    check("p6_init_cs_low", cl, 6);
    check("p6_init_write_low", wl, 1);
    we6 = 2'b00; addr6 = 2'd2; req6 = 2'b01;
    n = 0; cl = 0; rl = 0; got = 0;
    while (n < 30 && !got) begin
      @(posedge clk); #1;
      n++;
      if (!cs6) cl++;
      if (!read6) rl++;
      if (done6 != 2'b00) got = 1;
    end
    req6 = 2'b00;
    check("p6_latency", n, 7);
    check("p6_cs_low", cl, 6);
    check("p6_read_low", rl, 1);
    check("p6_rdata", rdata6, 8'h99);
    check("p6_done", done6, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
